// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle unsigned divide/modulo sequencer for mips_16.
// Restoring shift-subtract, one quotient bit per cycle, stalls IF/ID meanwhile.
module div_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_mod,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic             op_mod_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   t;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  logic             accept;
  logic             last;
  logic             dvs_zero;

  assign accept   = (state == S_IDLE) & start & ~flush;
  assign last     = (cnt == LAST);
  assign dvs_zero = (divisor == '0);

  // one restoring step: shift next dividend bit into the partial remainder
  always_comb begin
    t     = {rem, quo[WIDTH-1]};
    diff  = t - {1'b0, dvs};
    ge    = (t >= {1'b0, dvs});
    rem_n = ge ? diff[WIDTH-1:0] : t[WIDTH-1:0];
    quo_n = {quo[WIDTH-2:0], ge};
  end

  // next-state logic; flush overrides everything
  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state_n = dvs_zero ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (last) begin
            state_n = S_DONE;
          end
        end
        S_DONE: begin
          state_n = S_IDLE;
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  // stall must not wait a cycle: the request cycle itself freezes IF/ID
  assign stall = accept | (state == S_RUN);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // status flags registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_n != S_IDLE);
      done <= (state_n == S_DONE);
    end
  end

  // datapath: operand capture, iteration, result load
  always_ff @(posedge clk) begin
    if (rst) begin
      quo         <= '0;
      rem         <= '0;
      dvs         <= '0;
      op_mod_q    <= 1'b0;
      cnt         <= '0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      op_mod_q <= op_mod;
      dvs      <= divisor;
      quo      <= dividend;
      rem      <= '0;
      cnt      <= '0;
      if (dvs_zero) begin
        result      <= op_mod ? dividend : '1;
        div_by_zero <= 1'b1;
      end
    end else if ((state == S_RUN) && !flush) begin
      quo <= quo_n;
      rem <= rem_n;
      cnt <= cnt + 1'b1;
      if (last) begin
        result      <= op_mod_q ? rem_n : quo_n;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed bench for div_sequencer.
// Cycle n = interval after the n-th rising edge since the request.
module tb_div_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        op_mod;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [15:0] result;
  logic        div_by_zero;

  int checks;
  int failures;

  div_sequencer #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op_mod      (op_mod),
    .dividend    (dividend),
    .divisor     (divisor),
    .flush       (flush),
    .busy        (busy),
    .stall       (stall),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no_finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] a,
                        input logic [15:0] b,
                        input logic        m,
                        input logic [15:0] er,
                        input string       tag);
    start = 1'b1; op_mod = m; dividend = a; divisor = b;
    #1;
    chk({tag, "_c0_stall"}, 32'(stall), 32'd1);
    chk({tag, "_c0_busy"}, 32'(busy), 32'd0);
    step();
    start = 1'b0; op_mod = ~m;
    dividend = 16'hDEAD; divisor = 16'hBEEF;
    for (int c = 1; c <= 16; c++) begin
      #1;
      chk($sformatf("%s_c%0d_stall", tag, c), 32'(stall), 32'd1);
      chk($sformatf("%s_c%0d_busy", tag, c), 32'(busy), 32'd1);
      chk($sformatf("%s_c%0d_done", tag, c), 32'(done), 32'd0);
      step();
    end
    #1;
    chk({tag, "_c17_done"}, 32'(done), 32'd1);
    chk({tag, "_c17_result"}, 32'(result), 32'(er));
    chk({tag, "_c17_dbz"}, 32'(div_by_zero), 32'd0);
    chk({tag, "_c17_stall"}, 32'(stall), 32'd0);
    chk({tag, "_c17_busy"}, 32'(busy), 32'd1);
    step();
    #1;
    chk({tag, "_c18_busy"}, 32'(busy), 32'd0);
    chk({tag, "_c18_done"}, 32'(done), 32'd0);
    chk({tag, "_c18_hold"}, 32'(result), 32'(er));
  endtask

  task automatic run_dz(input logic [15:0] a,
                        input logic        m,
                        input logic [15:0] er,
                        input string       tag);
    start = 1'b1; op_mod = m; dividend = a; divisor = 16'h0000;
    #1;
    chk({tag, "_c0_stall"}, 32'(stall), 32'd1);
    step();
    start = 1'b0; dividend = 16'hDEAD; divisor = 16'hBEEF;
    #1;
    chk({tag, "_c1_done"}, 32'(done), 32'd1);
    chk({tag, "_c1_result"}, 32'(result), 32'(er));
    chk({tag, "_c1_dbz"}, 32'(div_by_zero), 32'd1);
    chk({tag, "_c1_busy"}, 32'(busy), 32'd1);
    chk({tag, "_c1_stall"}, 32'(stall), 32'd0);
    step();
    #1;
    chk({tag, "_c2_busy"}, 32'(busy), 32'd0);
    chk({tag, "_c2_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; start = 1'b0; op_mod = 1'b0;
    dividend = '0; divisor = '0; flush = 1'b0;
    step();
    step();
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    step();

    run_op(16'd100, 16'd7, 1'b0, 16'd14, "div100_7");
    run_op(16'd100, 16'd7, 1'b1, 16'd2, "mod100_7");
    run_op(16'hFFFF, 16'd1, 1'b0, 16'hFFFF, "divffff_1");
    run_op(16'd5, 16'hFFFF, 1'b1, 16'd5, "mod5_ffff");

    run_dz(16'h1234, 1'b0, 16'hFFFF, "dz_div");
    run_dz(16'h1234, 1'b1, 16'h1234, "dz_mod");

    // start while busy is ignored; reissue after DONE
    start = 1'b1; op_mod = 1'b0; dividend = 16'd200; divisor = 16'd9;
    #1;
    chk("ign_c0_stall", 32'(stall), 32'd1);
    step();
    for (int c = 1; c <= 16; c++) begin
      start = (c == 3);
      dividend = 16'd50; divisor = 16'd5;
      #1;
      chk($sformatf("ign_c%0d_stall", c), 32'(stall), 32'd1);
      chk($sformatf("ign_c%0d_done", c), 32'(done), 32'd0);
      step();
    end
    start = 1'b1;
    #1;
    chk("ign_c17_done", 32'(done), 32'd1);
    chk("ign_c17_result", 32'(result), 32'd22);
    chk("ign_c17_dbz", 32'(div_by_zero), 32'd0);
    chk("ign_c17_stall", 32'(stall), 32'd0);
    step();
    #1;
    chk("ign_c18_busy", 32'(busy), 32'd0);
    chk("ign_c18_stall", 32'(stall), 32'd1);
    step();
    start = 1'b0;
    for (int c = 19; c <= 34; c++) begin
      #1;
      chk($sformatf("re_c%0d_busy", c), 32'(busy), 32'd1);
      chk($sformatf("re_c%0d_done", c), 32'(done), 32'd0);
      step();
    end
    #1;
    chk("re_c35_done", 32'(done), 32'd1);
    chk("re_c35_result", 32'(result), 32'd10);
    step();

    // flush mid-run: no done, result holds
    start = 1'b1; op_mod = 1'b0; dividend = 16'd100; divisor = 16'd7;
    step();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) step();
    flush = 1'b1;
    #1;
    chk("fl_c8_busy", 32'(busy), 32'd1);
    step();
    flush = 1'b0;
    #1;
    chk("fl_c9_busy", 32'(busy), 32'd0);
    chk("fl_c9_stall", 32'(stall), 32'd0);
    chk("fl_c9_result", 32'(result), 32'd10);
    chk("fl_c9_dbz", 32'(div_by_zero), 32'd0);
    for (int c = 9; c <= 20; c++) begin
      chk($sformatf("fl_c%0d_done", c), 32'(done), 32'd0);
      step();
    end

    // flush beats start in IDLE
    start = 1'b1; flush = 1'b1; dividend = 16'd9; divisor = 16'd3;
    #1;
    chk("flpri_stall", 32'(stall), 32'd0);
    step();
    start = 1'b0; flush = 1'b0;
    #1;
    chk("flpri_busy", 32'(busy), 32'd0);
    chk("flpri_done", 32'(done), 32'd0);
    chk("flpri_result", 32'(result), 32'd10);

    // reset mid-run
    start = 1'b1; op_mod = 1'b1; dividend = 16'd100; divisor = 16'd7;
    step();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_result", 32'(result), 32'd0);
    chk("mrst_dbz", 32'(div_by_zero), 32'd0);
    chk("mrst_stall", 32'(stall), 32'd0);
    step();
    run_op(16'd30, 16'd4, 1'b0, 16'd7, "div30_4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle sequencer for the `ALU_DIV` / `ALU_MOD` operations of the mips_16 pipeline. It accepts one unsigned 16-bit divide request from the decode/execute boundary and runs a restoring shift-subtract iteration, one quotient bit per cycle. While the divide is in progress it drives a stall that freezes IF/ID (`instruction_decode_en` low). It then presents the quotient or remainder with a one-cycle `done` pulse for the EX-stage result mux.

## Interface

Parameters:
- `WIDTH`, default 16, operand/result width; the iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request strobe; sampled only in IDLE.
- `op_mod`  in  1  1 = return remainder (`ALU_MOD`), 0 = return quotient (`ALU_DIV`); latched with `start`.
- `dividend`  in  WIDTH  unsigned dividend; latched with `start`.
- `divisor`  in  WIDTH  unsigned divisor; latched with `start`.
- `flush`  in  1  abort the current operation with no result.
- `busy`  out  1  registered; high in RUN and DONE.
- `stall`  out  1  combinational; freezes IF/ID.
- `done`  out  1  registered; one-cycle pulse in DONE.
- `result`  out  WIDTH  registered; selected quotient or remainder.
- `div_by_zero`  out  1  registered; valid with `done`.

## Operation

- Reset value of every output is 0. The state is IDLE and all internal registers are cleared.
- State IDLE, with `start=1` and `flush=0`:
  - Latch `op_mod` and `divisor`.
  - `quo <= dividend`, `rem <= 0`, `cnt <= 0`.
  - If `divisor == 0`, go to DONE with `result = op_mod ? dividend : {WIDTH{1'b1}}` and `div_by_zero = 1`.
  - Otherwise go to RUN.
- State RUN, one step per cycle:
  - Form `t = {rem, quo[WIDTH-1]}`, which is WIDTH+1 bits.
  - If `t >= {1'b0, divisor}`: `rem <= t - divisor` (low WIDTH bits) and `quo <= {quo[WIDTH-2:0], 1'b1}`.
  - Else: `rem <= t[WIDTH-1:0]` and `quo <= {quo[WIDTH-2:0], 1'b0}`.
  - `cnt++`. After the step with `cnt == WIDTH-1`, go to DONE.
  - `result` is loaded on the RUN→DONE edge from the final values (remainder if `op_mod`, else quotient). `div_by_zero = 0`.
- State DONE: `done = 1` for exactly this cycle, then go to IDLE unconditionally.
- `result` and `div_by_zero` hold their value until the next accepted `start`.
- `start` in RUN or DONE is ignored. No queueing; the pipeline is stalled, so a bench that asserts it must see no effect.
- `flush=1` in any state:
  - Next state is IDLE.
  - `done` is not asserted on the following cycle.
  - `result` and `div_by_zero` keep their prior values.
  - `flush` has priority over `start` in IDLE.
- `rst` mid-operation returns all registers and outputs to reset values on the next edge.
- `stall = (state==IDLE & start & ~flush) | (state==RUN)`. It is low in DONE, so the pipeline advances in the same cycle the result is valid.

## Timing

- Cycle 0: `start` is sampled in IDLE and `stall=1` combinationally.
- Cycles 1..WIDTH: RUN. `busy=1`, `stall=1`.
- Cycle WIDTH+1 (17 for default): DONE. `done=1`, `result` valid, `busy=1`, `stall=0`.
- Cycle WIDTH+2: IDLE. `busy=0`. A new `start` is accepted here at the earliest, so back-to-back throughput is one op per WIDTH+2 cycles.
- Divide-by-zero: DONE in cycle 1, so latency is 1 cycle. `stall` is high in cycle 0 only.
- No combinational path from `dividend`/`divisor` to any output. `stall` depends only on `state`, `start`, `flush`.

## Test plan

- `dividend=100`, `divisor=7`, `op_mod=0` → `done` at cycle 17 with `result=14`, `div_by_zero=0`. Repeat with `op_mod=1` → `result=2`. `stall` is high in cycles 0..16 and low in cycle 17.
- `dividend=16'hFFFF`, `divisor=1`, `op_mod=0` → `result=16'hFFFF`. Then `dividend=5`, `divisor=16'hFFFF`, `op_mod=1` → `result=5`.
- `divisor=0`, `dividend=16'h1234`: with `op_mod=0` → `done` at cycle 1, `result=16'hFFFF`, `div_by_zero=1`. With `op_mod=1` → `result=16'h1234`.
- Start 200/9, then assert `start` with 50/5 in cycles 3 and 17 → the second start is ignored and `result=22`. Re-issue 50/5 in cycle 18 → `result=10` at cycle 35.
- Start 100/7, assert `flush` at cycle 8 → IDLE at cycle 9. No `done` pulse, `result` keeps its previous value, `stall=0` from cycle 9.
- Start 100/7, assert `rst` at cycle 5 → at cycle 6 all outputs are 0 and `busy=0`. A fresh 30/4 request completes with `result=7`.
